bcd_seq_converter: RTL and testbench

//   Sequential double-dabble binary-to-BCD converter with a valid/ready handshake.

---
 rtl/bcd_seq_converter.sv | 141 ++++++++++++++
 tb/tb_bcd_seq_converter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_converter.sv
//-----------------------------------------------------------------------------
// bcd_seq_converter
//   Sequential double-dabble binary-to-BCD converter with valid/ready
//   handshakes. One add-3/shift step per clock, so only one adjust stage is
//   needed regardless of WIDTH. A result appears exactly WIDTH clocks after
//   the accepting edge and is held until the consumer takes it.
//
//   Optional feature macro: BCD_BLANK_EN
//     When defined, adds output blank[DIGITS-1:0] (leading-zero blanking
//     flags, registered with bcd_out). When undefined the port is absent.
//-----------------------------------------------------------------------------
module bcd_seq_converter #(
   parameter int WIDTH  = 16,
   parameter int DIGITS = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      bin_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  ovf
`ifdef BCD_BLANK_EN
   ,
   output logic [DIGITS-1:0]     blank
`endif
);

   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t            r_state;
   logic [WIDTH-1:0]  r_bin;          // binary bits still to be shifted in
   logic [BW-1:0]     r_acc;          // BCD accumulator
   logic              r_ovf_sticky;   // a 1 has left the top digit
   logic [CW-1:0]     r_count;        // shift steps remaining

   logic [BW-1:0]     w_adj;
   logic [BW-1:0]     w_acc_next;
   logic              w_carry;
   logic              w_last;

   // Add-3 adjust on every digit, then the one-bit shift of {acc, bin}
   always_comb begin
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      w_adj = r_acc;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_acc[4*d +: 4] >= 4'd5)
            w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
      w_acc_next = {w_adj[BW-2:0], r_bin[WIDTH-1]};
      w_carry    = w_adj[BW-1];
      w_last     = (r_count == CW'(1));
   end

`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0] w_blank_next;

   // Blank flag for digit i: it and every higher digit of the new result are zero
   always_comb begin
      logic v_nz;
      w_blank_next = '0;
      v_nz         = 1'b0;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         v_nz            = v_nz | (|w_acc_next[4*i +: 4]);
         w_blank_next[i] = ~v_nz;
      end
   end
`endif

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         r_state      <= S_IDLE;
         r_bin        <= '0;
         r_acc        <= '0;
         r_ovf_sticky <= 1'b0;
         r_count      <= '0;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         bcd_out      <= '0;
         ovf          <= 1'b0;
`ifdef BCD_BLANK_EN
         blank        <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_bin        <= bin_in;
                  r_acc        <= '0;
                  r_ovf_sticky <= 1'b0;
                  r_count      <= CW'(WIDTH);
                  in_ready     <= 1'b0;
                  r_state      <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               r_acc        <= w_acc_next;
               r_bin        <= r_bin << 1;
               r_count      <= r_count - CW'(1);
               r_ovf_sticky <= r_ovf_sticky | w_carry;
               if (w_last) begin
                  bcd_out   <= w_acc_next;
                  ovf       <= r_ovf_sticky | w_carry;
                  out_valid <= 1'b1;
`ifdef BCD_BLANK_EN
                  blank     <= w_blank_next;
`endif
                  r_state   <= S_DONE;
               end
            end

            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  r_state   <= S_IDLE;
               end
            end

            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_seq_converter.sv
//-----------------------------------------------------------------------------
// tb_bcd_seq_converter
//   Self-checking bench for bcd_seq_converter. Instance A is 16-bit/5-digit,
//   instance B is 8-bit/2-digit (overflow cases). Expected results are pushed
//   to a per-instance queue when an input is accepted and popped when the
//   consumer takes the result.
//-----------------------------------------------------------------------------
module tb_bcd_seq_converter;

   typedef struct packed {
      logic [19:0] bcd;
      logic        ovf;
      logic [4:0]  blank;
   } exp_t;

   typedef struct packed {
      logic [15:0] bin;
      logic [19:0] bcd;
      logic        ovf;
   } vec_t;

   logic clk    = 1'b0;
   logic clk_en = 1'b0;
   logic rst    = 1'b0;

   logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0, a_ovf;
   logic [15:0] a_bin_in = '0;
   logic [19:0] a_bcd_out;
   logic [4:0]  a_blank;

   logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0, b_ovf;
   logic [7:0]  b_bin_in = '0;
   logic [7:0]  b_bcd_out;
   logic [1:0]  b_blank;

   int n_checks = 0;
   int n_errors = 0;

   exp_t q_a[$];
   exp_t q_b[$];

   always begin
      #5;
      if (clk_en) clk = ~clk;
   end

   bcd_seq_converter #(.WIDTH(16), .DIGITS(5)) dut_a (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .bin_in    (a_bin_in),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .bcd_out   (a_bcd_out),
      .ovf       (a_ovf)
`ifdef BCD_BLANK_EN
      ,
      .blank     (a_blank)
`endif
   );

   bcd_seq_converter #(.WIDTH(8), .DIGITS(2)) dut_b (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .bin_in    (b_bin_in),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .bcd_out   (b_bcd_out),
      .ovf       (b_ovf)
`ifdef BCD_BLANK_EN
      ,
      .blank     (b_blank)
`endif
   );

`ifndef BCD_BLANK_EN
   assign a_blank = '0;
   assign b_blank = '0;
`endif

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference by repeated division: digits of v mod 10^digits, overflow flag, blanking
   function automatic exp_t model(input int unsigned v, input int digits);
      exp_t        r;
      int unsigned x;
      logic        nz;
      r  = '0;
      x  = v;
      for (int d = 0; d < digits; d++) begin
         r.bcd[4*d +: 4] = 4'(x % 10);
         x = x / 10;
      end
      r.ovf = (x != 0);
      nz    = 1'b0;
      for (int i = digits - 1; i >= 1; i--) begin
         nz         = nz | (r.bcd[4*i +: 4] != 4'd0);
         r.blank[i] = ~nz;
      end
      return r;
   endfunction

   // Present one value for one edge; called #1 after a rising edge with the DUT idle
   task automatic send(input int sel, input int unsigned v, input exp_t e);
      if (sel == 0) begin
         check("a_in_ready_idle", 32'(a_in_ready), 32'd1);
         a_in_valid = 1'b1;
         a_bin_in   = 16'(v);
      end else begin
         check("b_in_ready_idle", 32'(b_in_ready), 32'd1);
         b_in_valid = 1'b1;
         b_bin_in   = 8'(v);
      end
      @(posedge clk);
      #1;
      if (sel == 0) begin
         a_in_valid = 1'b0;
         q_a.push_back(e);
         check("a_in_ready_busy", 32'(a_in_ready), 32'd0);
      end else begin
         b_in_valid = 1'b0;
         q_b.push_back(e);
         check("b_in_ready_busy", 32'(b_in_ready), 32'd0);
      end
   endtask

   // Count edges from the accepting edge until out_valid, bounded
   task automatic wait_result(input int sel, input int exp_lat, output bit ok);
      int lat;
      lat = 0;
      ok  = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(posedge clk);
         #1;
         if ((sel == 0) ? a_out_valid : b_out_valid) begin
            lat = k;
            ok  = 1'b1;
            break;
         end
      end
      check("result_arrived", 32'(ok), 32'd1);
      if (ok) check("latency", 32'(lat), 32'(exp_lat));
      else if (sel == 0) q_a.delete();
      else q_b.delete();
   endtask

   // Compare the held result against the scoreboard, then hand it off for one edge
   task automatic take(input int sel);
      exp_t e;
      if (sel == 0) begin
         if (q_a.size() == 0) begin
            check("a_scoreboard_nonempty", 32'(q_a.size()), 32'd1);
            return;
         end
         e = q_a.pop_front();
         check("a_bcd_out", 32'(a_bcd_out), 32'(e.bcd));
         check("a_ovf", 32'(a_ovf), 32'(e.ovf));
`ifdef BCD_BLANK_EN
         check("a_blank", 32'(a_blank), 32'(e.blank));
`endif
         a_out_ready = 1'b1;
      end else begin
         if (q_b.size() == 0) begin
            check("b_scoreboard_nonempty", 32'(q_b.size()), 32'd1);
            return;
         end
         e = q_b.pop_front();
         check("b_bcd_out", 32'(b_bcd_out), 32'(e.bcd[7:0]));
         check("b_ovf", 32'(b_ovf), 32'(e.ovf));
`ifdef BCD_BLANK_EN
         check("b_blank", 32'(b_blank), 32'(e.blank[1:0]));
`endif
         b_out_ready = 1'b1;
      end
      @(posedge clk);
      #1;
      a_out_ready = 1'b0;
      b_out_ready = 1'b0;
      if (sel == 0) begin
         check("a_out_valid_drop", 32'(a_out_valid), 32'd0);
         check("a_in_ready_back", 32'(a_in_ready), 32'd1);
      end else begin
         check("b_out_valid_drop", 32'(b_out_valid), 32'd0);
         check("b_in_ready_back", 32'(b_in_ready), 32'd1);
      end
   endtask

   task automatic convert(input int sel, input int unsigned v, input exp_t e, input int lat);
      bit ok;
      send(sel, v, e);
      wait_result(sel, lat, ok);
      if (ok) take(sel);
   endtask

   initial begin
      vec_t tbl_a[6];
      vec_t tbl_b[3];
      exp_t e;
      bit   ok;
      int   any_valid;

      tbl_a[0] = '{bin: 16'd12345, bcd: 20'h12345, ovf: 1'b0};
      tbl_a[1] = '{bin: 16'd65535, bcd: 20'h65535, ovf: 1'b0};
      tbl_a[2] = '{bin: 16'd0,     bcd: 20'h00000, ovf: 1'b0};
      tbl_a[3] = '{bin: 16'd9,     bcd: 20'h00009, ovf: 1'b0};
      tbl_a[4] = '{bin: 16'd10,    bcd: 20'h00010, ovf: 1'b0};
      tbl_a[5] = '{bin: 16'd40960, bcd: 20'h40960, ovf: 1'b0};

      tbl_b[0] = '{bin: 16'd255, bcd: 20'h00055, ovf: 1'b1};
      tbl_b[1] = '{bin: 16'd99,  bcd: 20'h00099, ovf: 1'b0};
      tbl_b[2] = '{bin: 16'd100, bcd: 20'h00000, ovf: 1'b1};

      // Reset with the clock stopped takes effect immediately
      #3 rst = 1'b1;
      #1;
      check("rst_a_in_ready", 32'(a_in_ready), 32'd1);
      check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
      check("rst_a_bcd_out", 32'(a_bcd_out), 32'd0);
      check("rst_a_ovf", 32'(a_ovf), 32'd0);
      check("rst_b_in_ready", 32'(b_in_ready), 32'd1);
      check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
      #4 rst = 1'b0;
      clk_en = 1'b1;
      @(posedge clk);
      #1;

      // Table-driven conversions on the 16-bit instance
      for (int i = 0; i < 6; i++) begin
         e     = model(32'(tbl_a[i].bin), 5);
         e.bcd = tbl_a[i].bcd;
         e.ovf = tbl_a[i].ovf;
         convert(0, 32'(tbl_a[i].bin), e, 16);
      end

      // Table-driven conversions on the 8-bit/2-digit instance (overflow)
      for (int i = 0; i < 3; i++) begin
         e     = model(32'(tbl_b[i].bin), 2);
         e.bcd = tbl_b[i].bcd;
         e.ovf = tbl_b[i].ovf;
         convert(1, 32'(tbl_b[i].bin), e, 8);
      end

      // Random values against the division model
      for (int i = 0; i < 6; i++) begin
         int unsigned v;
         v = $urandom_range(0, 65535);
         convert(0, v, model(v, 5), 16);
         v = $urandom_range(0, 255);
         convert(1, v, model(v, 2), 8);
      end

      // Back-pressure in DONE with a pending input; no same-cycle re-accept
      send(0, 12345, model(12345, 5));
      wait_result(0, 16, ok);
      a_in_valid = 1'b1;
      a_bin_in   = 16'd7;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         check("hold_in_ready", 32'(a_in_ready), 32'd0);
         check("hold_out_valid", 32'(a_out_valid), 32'd1);
         check("hold_bcd_stable", 32'(a_bcd_out), 32'h12345);
      end
      take(0);
      q_a.push_back(model(7, 5));
      @(posedge clk);
      #1;
      a_in_valid = 1'b0;
      a_bin_in   = 16'd0;
      check("reaccept_in_ready", 32'(a_in_ready), 32'd0);
      check("bcd_kept_after_drop", 32'(a_bcd_out), 32'h12345);
      wait_result(0, 16, ok);
      if (ok) take(0);

      // Reset in the middle of a conversion aborts it
      send(0, 200, model(200, 5));
      for (int k = 0; k < 7; k++) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      check("abort_in_ready", 32'(a_in_ready), 32'd1);
      check("abort_out_valid", 32'(a_out_valid), 32'd0);
      check("abort_bcd_out", 32'(a_bcd_out), 32'd0);
      check("abort_ovf", 32'(a_ovf), 32'd0);
      q_a.delete();
      q_b.delete();
      #2 rst = 1'b0;
      any_valid = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (a_out_valid) any_valid++;
      end
      check("abort_no_result", 32'(any_valid), 32'd0);
      convert(0, 42, model(42, 5), 16);
`ifdef BCD_BLANK_EN
      check("blank_42", 32'(a_blank), 32'h1C);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
